// File: rtl/encoder_8x3_sequencer.sv
// encoder_8x3_sequencer
//   Captures an 8-bit request vector over a valid/ready handshake, then emits one binary
//   code per set bit, highest priority first, on a valid/ready output stream. Each bit is
//   cleared as its code is accepted. This is the inverse companion of a 3-to-8 decoder.
//
// Parameters
//   IN_W       request vector width (8)
//   OUT_W      code width, clog2(IN_W)
//   LSB_FIRST  0: bit IN_W-1 has highest priority; 1: bit 0 has highest priority
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   req_valid   req_vec is valid
//   req_ready   block is idle and can capture a vector
//   req_vec     request vector, any number of bits set
//   code_valid  code is valid
//   code_ready  downstream accepts code
//   code        index of the highest-priority pending bit (0 when code_valid=0)
//   code_last   this code is the final pending bit
//   zero_req    one-cycle pulse after an all-zero vector is accepted
module encoder_8x3_sequencer #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_W     = 3,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IN_W-1:0]  req_vec,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [OUT_W-1:0] code,
    output logic             code_last,
    output logic             zero_req
);

    typedef enum logic [0:0] {StIdle, StServe} state_e;

    localparam logic [IN_W-1:0] VecOne = IN_W'(1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   pending_q, pending_d;
    logic              zero_q, zero_d;

    logic [OUT_W-1:0]  sel_idx;
    logic              sel_one;
    logic              has_pending;

    // Priority select over the pending vector. The loop runs from lowest to highest
    // priority so the last match wins.
    always_comb begin
        sel_idx = '0;
        if (LSB_FIRST) begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (pending_q[i]) sel_idx = i[OUT_W-1:0];
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (pending_q[i]) sel_idx = i[OUT_W-1:0];
            end
        end
    end

    assign has_pending = (pending_q != '0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign sel_one     = has_pending && ((pending_q & (pending_q - VecOne)) == '0);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_d     = 1'b0;
        req_ready  = 1'b0;
        code_valid = 1'b0;
        code       = '0;
        code_last  = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_vec != '0) begin
                        pending_d = req_vec;
                        state_d   = StServe;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            StServe: begin
                if (!has_pending) begin
                    // Unreachable in normal operation; recover quietly.
                    state_d = StIdle;
                end else begin
                    code_valid = 1'b1;
                    code       = sel_idx;
                    code_last  = sel_one;
                    if (code_ready) begin
                        pending_d = pending_q & ~(VecOne << sel_idx);
                        if (sel_one) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

    assign zero_req = zero_q;

endmodule
